// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions: store func3 encodings, store error codes,
// the store-queue entry layout and the store-buffer FSM states.
package riscv_mem_pkg;

  // func3 encodings shared by the store formatter and the load extractor
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // store error causes
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  // one queued store: word address, lane-replicated data, byte strobes
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'b00,
    SB_DRAIN = 2'b01,
    SB_DONE  = 2'b10
  } sb_state_t;

  // True when a queued store writes at least one byte the load may read.
  function automatic logic entry_hits_word(input store_entry_t e,
                                           input logic [29:0]  word_addr,
                                           input logic [3:0]   load_strb);
    return (e.addr == word_addr) && ((e.wstrb & load_strb) != 4'b0000);
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Register FIFO for formatted stores. Exposes the head entry (zero when
// empty), the occupancy and every slot with its valid bit so the parent can
// compare all queued stores against an in-flight load.
module store_fifo
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  store_entry_t     push_entry,
  input  logic             pop,
  output store_entry_t     head,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [DEPTH-1:0] entry_valid,
  output store_entry_t     entries [DEPTH]
);

  store_entry_t     mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [DEPTH-1:0] valid_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [DEPTH-1:0] push_mask_s;
  logic [DEPTH-1:0] pop_mask_s;

  // Gate push/pop on full/empty so pointers and valid bits never corrupt.
  always_comb begin
    do_push_s   = push & (count_r != CW'(DEPTH));
    do_pop_s    = pop & (count_r != {CW{1'b0}});
    push_mask_s = do_push_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr_r) : {DEPTH{1'b0}};
    pop_mask_s  = do_pop_s  ? ({{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr_r) : {DEPTH{1'b0}};
  end

  // Storage, pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(store_entry_t){1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      valid_r <= (valid_r | push_mask_s) & ~pop_mask_s;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry straight from storage; forced to zero while the queue is empty.
  always_comb begin
    if (count_r == {CW{1'b0}}) begin
      head = {$bits(store_entry_t){1'b0}};
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // Export every slot for the load-hazard compare.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem_r[i];
    end
  end

  assign empty       = (count_r == {CW{1'b0}});
  assign count       = count_r;
  assign entry_valid = valid_r;

endmodule

// File: rtl/s_type_store_buffer.sv
// Store buffer: formats SB/SH/SW into word-aligned strobed writes, rejects
// illegal/misaligned requests, queues legal ones and drains them to memory
// over valid/ready. A fence drains the queue and acknowledges with a pulse;
// load_hazard flags any queued store to the word of an in-flight load.
module s_type_store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] rs2_data,
  input  logic        fence_valid,
  output logic        fence_done,
  input  logic [31:0] load_addr,
  output logic        load_hazard,
  output logic        store_err,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        empty
);

  localparam int         CW        = $clog2(DEPTH + 1);
  // loads are not size-qualified here, so assume they read the whole word
  localparam logic [3:0] LOAD_STRB = 4'b1111;

  logic [1:0]       off_s;
  logic [3:0]       fmt_strb_s;
  logic [31:0]      fmt_wdata_s;
  logic             fmt_illegal_s;
  logic             fmt_misalign_s;
  logic             accept_s;
  logic             push_s;
  logic             reject_s;
  logic             pop_s;
  store_entry_t     push_entry_s;
  store_entry_t     head_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    count_s;
  logic [DEPTH-1:0] entry_valid_s;
  store_entry_t     entries_s [DEPTH];
  logic             hazard_s;
  logic             load_addr_unused_s;

  sb_state_t        state_r;
  logic             fence_done_r;
  logic             store_err_r;
  logic [1:0]       err_cause_r;
  logic [31:0]      err_addr_r;

  assign off_s = address[1:0];

  // Lane placement, data replication and legality of the incoming store.
  always_comb begin
    fmt_strb_s     = 4'b0000;
    fmt_wdata_s    = 32'h0000_0000;
    fmt_illegal_s  = 1'b0;
    fmt_misalign_s = 1'b0;
    case (func3)
      F3_SB: begin
        fmt_strb_s  = 4'b0001 << off_s;
        fmt_wdata_s = {4{rs2_data[7:0]}};
      end
      F3_SH: begin
        fmt_strb_s     = 4'b0011 << off_s;
        fmt_wdata_s    = {2{rs2_data[15:0]}};
        fmt_misalign_s = off_s[0];
      end
      F3_SW: begin
        fmt_strb_s     = 4'b1111;
        fmt_wdata_s    = rs2_data;
        fmt_misalign_s = (off_s != 2'b00);
      end
      default: begin
        fmt_illegal_s = 1'b1;
      end
    endcase
  end

  // No full-bypass: a full queue refuses even if it pops this cycle.
  assign req_ready = (state_r == SB_IDLE) && (count_s != CW'(DEPTH));
  assign accept_s  = req_valid & req_ready;
  assign reject_s  = accept_s & (fmt_illegal_s | fmt_misalign_s);
  assign push_s    = accept_s & ~fmt_illegal_s & ~fmt_misalign_s;
  assign pop_s     = ~fifo_empty_s & mem_ready;

  assign push_entry_s.addr  = address[31:2];
  assign push_entry_s.wdata = fmt_wdata_s;
  assign push_entry_s.wstrb = fmt_strb_s;

  store_fifo #(
    .DEPTH(DEPTH)
  ) u_store_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .empty      (fifo_empty_s),
    .count      (count_s),
    .entry_valid(entry_valid_s),
    .entries    (entries_s)
  );

  assign mem_valid = ~fifo_empty_s;
  assign mem_addr  = {head_s.addr, 2'b00};
  assign mem_wdata = head_s.wdata;
  assign mem_wstrb = head_s.wstrb;
  assign empty     = fifo_empty_s;

  // Rejected request: pulse store_err and latch cause/address until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_err_r <= 1'b0;
      err_cause_r <= ERR_NONE;
      err_addr_r  <= 32'h0000_0000;
    end else if (reject_s) begin
      store_err_r <= 1'b1;
      err_cause_r <= fmt_illegal_s ? ERR_ILLEGAL : ERR_MISALIGN;
      err_addr_r  <= address;
    end else begin
      store_err_r <= 1'b0;
    end
  end

  // Fence sequencer: block new stores, wait for an empty queue, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SB_IDLE;
      fence_done_r <= 1'b0;
    end else begin
      case (state_r)
        SB_IDLE: begin
          fence_done_r <= 1'b0;
          if (fence_valid) begin
            state_r <= SB_DRAIN;
          end else begin
            state_r <= SB_IDLE;
          end
        end
        SB_DRAIN: begin
          if (count_s == {CW{1'b0}}) begin
            state_r      <= SB_DONE;
            fence_done_r <= 1'b1;
          end else begin
            state_r      <= SB_DRAIN;
            fence_done_r <= 1'b0;
          end
        end
        SB_DONE: begin
          state_r      <= SB_IDLE;
          fence_done_r <= 1'b0;
        end
        default: begin
          state_r      <= SB_IDLE;
          fence_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Any valid entry (including one popping now) to the load's word is a hazard.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_s = hazard_s |
                 (entry_valid_s[i] & entry_hits_word(entries_s[i], load_addr[31:2], LOAD_STRB));
    end
  end

  // byte offset of the load does not matter with a whole-word load strobe
  assign load_addr_unused_s = ^load_addr[1:0];

  assign load_hazard = hazard_s;
  assign fence_done  = fence_done_r;
  assign store_err   = store_err_r;
  assign err_cause   = err_cause_r;
  assign err_addr    = err_addr_r;

endmodule

// File: tb/tb_s_type_store_buffer.sv
// Scoreboard bench for s_type_store_buffer: the stimulus side predicts each
// write/error from the store rules and queues it; a negedge monitor compares.
module tb_s_type_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] rs2_data;
  logic        fence_valid;
  logic        fence_done;
  logic [31:0] load_addr;
  logic        load_hazard;
  logic        store_err;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        empty;

  s_type_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .func3(func3), .address(address), .rs2_data(rs2_data),
    .fence_valid(fence_valid), .fence_done(fence_done),
    .load_addr(load_addr), .load_hazard(load_hazard),
    .store_err(store_err), .err_cause(err_cause), .err_addr(err_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .empty(empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] addr;
  } er_t;

  wr_t exp_q[$];
  er_t err_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  pend  = 0;     // 1 while a legal store is offered but not yet clocked in
  int  fd_cnt = 0;
  logic [1:0]  last_cause = 2'b00;
  logic [31:0] last_addr  = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what memory write or error a request must produce.
  task automatic model_push(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output bit legal);
    int  size;
    int  off;
    wr_t w;
    er_t e;
    off = int'(a % 32'd4);
    case (f3)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      default: size = 0;
    endcase
    legal = 1'b0;
    if (size == 0) begin
      e.cause = 2'b10; e.addr = a; err_q.push_back(e);
      last_cause = 2'b10; last_addr = a;
    end else if ((off % size) != 0) begin
      e.cause = 2'b01; e.addr = a; err_q.push_back(e);
      last_cause = 2'b01; last_addr = a;
    end else begin
      w.addr  = a - 32'(off);
      w.wstrb = 4'(((1 << size) - 1) << off);
      if (size == 1)      w.wdata = 32'(d[7:0]) * 32'h0101_0101;
      else if (size == 2) w.wdata = 32'(d[15:0]) * 32'h0001_0001;
      else                w.wdata = d;
      exp_q.push_back(w);
      legal = 1'b1;
    end
  endtask

  // Offer one request (called just after a rising edge); waits while not ready.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit legal;
    n = 0;
    chk("req_ready_model", req_ready, (exp_q.size() != DEPTH));
    req_valid = 1'b1; func3 = f3; address = a; rs2_data = d;
    while (!req_ready && n < 200) begin
      mem_ready = 1'b1;
      cyc();
      n++;
    end
    if (!req_ready) begin
      chk("req_wait_timeout", 32'(n), 32'd0);
      req_valid = 1'b0;
    end else begin
      model_push(f3, a, d, legal);
      pend = legal ? 1 : 0;
      cyc();
      pend = 0;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: checks hazard, presented write and error pulses against the queues.
  int   m_in;
  logic m_haz;
  always @(negedge clk) begin
    if (rst_n) begin
      m_in  = exp_q.size() - pend;
      m_haz = 1'b0;
      for (int i = 0; i < m_in; i++) begin
        if (exp_q[i].addr[31:2] == load_addr[31:2]) m_haz = 1'b1;
      end
      chk("load_hazard", load_hazard, m_haz);
      chk("mem_valid", mem_valid, (m_in != 0));
      if (mem_valid && m_in != 0) begin
        chk("mem_addr", mem_addr, exp_q[0].addr);
        chk("mem_wdata", mem_wdata, exp_q[0].wdata);
        chk("mem_wstrb", mem_wstrb, exp_q[0].wstrb);
        if (mem_ready) void'(exp_q.pop_front());
      end else if (!mem_valid) begin
        chk("idle_mem_bus", {mem_addr ^ mem_wdata, mem_wstrb} == 36'h0 ? 32'd0 : 32'd1, 32'd0);
        chk("empty_flag", empty, 1'b1);
      end
      if (store_err) begin
        if (err_q.size() == 0) begin
          chk("store_err_unexpected", store_err, 1'b0);
        end else begin
          chk("err_cause", err_cause, err_q[0].cause);
          chk("err_addr", err_addr, err_q[0].addr);
          void'(err_q.pop_front());
        end
      end
      if (fence_done) fd_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd0;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; func3 = 3'b000; address = 32'h0; rs2_data = 32'h0;
    fence_valid = 1'b0; load_addr = 32'hFFFF_FFF0; mem_ready = 1'b0;
    cyc(); cyc();
    // reset state
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_fence_done", fence_done, 1'b0);
    chk("rst_store_err", store_err, 1'b0);
    chk("rst_err_cause", err_cause, 2'b00);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    rst_n = 1'b1;
    cyc();

    // 1: SB to byte 3
    mem_ready = 1'b1;
    send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    chk("t1_mem_valid", mem_valid, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h0000_1000);
    chk("t1_mem_wdata", mem_wdata, 32'hDDDD_DDDD);
    chk("t1_mem_wstrb", mem_wstrb, 4'b1000);
    cyc();
    chk("t1_empty", empty, 1'b1);

    // 2: rejections, illegal beats misaligned
    send(3'b001, 32'h0000_2001, 32'h1234_5678);
    chk("t2_store_err", store_err, 1'b1);
    chk("t2_cause", err_cause, 2'b01);
    chk("t2_addr", err_addr, 32'h0000_2001);
    chk("t2_empty", empty, 1'b1);
    cyc();
    chk("t2_err_pulse", store_err, 1'b0);
    chk("t2_cause_held", err_cause, 2'b01);
    send(3'b011, 32'h0000_2004, 32'h0);
    chk("t2_illegal", err_cause, 2'b10);
    send(3'b111, 32'h0000_2003, 32'h0);
    chk("t2_prio", err_cause, 2'b10);
    chk("t2_prio_addr", err_addr, 32'h0000_2003);
    cyc();

    // 3: fill with backpressure, then release
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(3'b010, 32'h0000_5000 + 32'(i * 4), $urandom());
    chk("t3_full_ready", req_ready, 1'b0);
    cyc(); cyc(); cyc();
    drain();
    cyc();
    chk("t3_ready_back", req_ready, 1'b1);

    // 4: fence with two queued
    mem_ready = 1'b0;
    send(3'b010, 32'h0000_6000, $urandom());
    send(3'b001, 32'h0000_6006, $urandom());
    fd0 = fd_cnt;
    fence_valid = 1'b1;
    cyc();
    chk("t4_ready_drain", req_ready, 1'b0);
    mem_ready = 1'b1;
    n = 0;
    while (!fence_done && n < 50) begin
      chk("t4_ready_blocked", req_ready, 1'b0);
      cyc();
      n++;
    end
    chk("t4_fence_done", fence_done, 1'b1);
    chk("t4_all_popped", 32'(exp_q.size()), 32'd0);
    fence_valid = 1'b0;
    cyc();
    chk("t4_done_pulse", fence_done, 1'b0);
    chk("t4_idle_ready", req_ready, 1'b1);
    chk("t4_pulse_count", 32'(fd_cnt - fd0), 32'd1);

    // fence on an empty queue: done two cycles later
    fence_valid = 1'b1;
    cyc();
    chk("t4e_not_yet", fence_done, 1'b0);
    cyc();
    chk("t4e_done", fence_done, 1'b1);
    fence_valid = 1'b0;
    cyc();
    chk("t4e_ready", req_ready, 1'b1);

    // 5: load hazard
    mem_ready = 1'b0;
    send(3'b010, 32'h0000_3000, 32'hCAFE_F00D);
    load_addr = 32'h0000_3002;
    #1 chk("t5_hit", load_hazard, 1'b1);
    load_addr = 32'h0000_3004;
    #1 chk("t5_miss", load_hazard, 1'b0);
    cyc();
    load_addr = 32'hFFFF_FFF0;
    drain();

    // 6: reset with queued stores mid-handshake
    mem_ready = 1'b0;
    send(3'b000, 32'h0000_7001, $urandom());
    send(3'b001, 32'h0000_7002, $urandom());
    send(3'b010, 32'h0000_7008, $urandom());
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_mem_valid", mem_valid, 1'b0);
    chk("t6_empty", empty, 1'b1);
    exp_q.delete();
    err_q.delete();
    pend = 0;
    last_cause = 2'b00;
    last_addr  = 32'h0;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_still_empty", empty, 1'b1);
    chk("t6_ready", req_ready, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [2:0] f3;
      mem_ready = ($urandom_range(0, 3) != 0);
      load_addr = 32'h0000_4000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 9));
        f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
        send(f3, 32'h0000_4000 + 32'($urandom_range(0, 31)), $urandom());
      end else begin
        cyc();
      end
    end
    drain();
    cyc(); cyc();
    chk("final_err_q", 32'(err_q.size()), 32'd0);
    chk("final_err_cause", err_cause, last_cause);
    chk("final_err_addr", err_addr, last_addr);
    chk("final_empty", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
